// File: rtl/mox125_pkg.sv
// Shared widths, retire-FIFO geometry and the writeback entry type for the writeback stage.
package mox125_pkg;

   localparam int unsigned REG_IDX_W = 4;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned WB_DEPTH  = 2;
   localparam int unsigned WB_PTR_W  = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
   localparam int unsigned WB_CNT_W  = $clog2(WB_DEPTH + 1);

   typedef struct packed {
      logic                 we0;
      logic [REG_IDX_W-1:0] idx0;
      logic [DATA_W-1:0]    val0;
      logic                 we1;
      logic [REG_IDX_W-1:0] idx1;
      logic [DATA_W-1:0]    val1;
   } wb_entry_t;

   // Pointer increment that also wraps correctly for non-power-of-two depths.
   function automatic logic [WB_PTR_W-1:0] wb_ptr_inc(input logic [WB_PTR_W-1:0] ptr);
      if (ptr == WB_PTR_W'(WB_DEPTH - 1)) begin
         return '0;
      end
      return ptr + WB_PTR_W'(1);
   endfunction

endpackage

// File: rtl/cpu_writeback_if.sv
// Memory-to-writeback retire handshake; signal names follow the writeback stage's view.
interface cpu_writeback_if;
   import mox125_pkg::*;

   logic                 mw_valid_i;
   logic                 mw_ready_o;
   logic                 mw_we0_i;
   logic [REG_IDX_W-1:0] mw_idx0_i;
   logic [DATA_W-1:0]    mw_val0_i;
   logic                 mw_we1_i;
   logic [REG_IDX_W-1:0] mw_idx1_i;
   logic [DATA_W-1:0]    mw_val1_i;

   modport master (
      output mw_valid_i, mw_we0_i, mw_idx0_i, mw_val0_i, mw_we1_i, mw_idx1_i, mw_val1_i,
      input  mw_ready_o
   );

   modport slave (
      input  mw_valid_i, mw_we0_i, mw_idx0_i, mw_val0_i, mw_we1_i, mw_idx1_i, mw_val1_i,
      output mw_ready_o
   );

endinterface

// File: rtl/cpu_wb_fifo.sv
// In-order retire buffer of WB_DEPTH writeback entries; push when full and pop when empty
// are ignored.
module cpu_wb_fifo
   import mox125_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                push_i,
   input  wb_entry_t           data_i,
   input  logic                pop_i,
   output wb_entry_t           data_o,
   output logic                full_o,
   output logic                empty_o,
   output logic [WB_CNT_W-1:0] count_o
);

   wb_entry_t           r_mem [WB_DEPTH];
   logic [WB_PTR_W-1:0] r_wr_ptr;
   logic [WB_PTR_W-1:0] r_rd_ptr;
   logic [WB_CNT_W-1:0] r_count;
   logic                w_do_push;
   logic                w_do_pop;

   assign full_o    = (r_count == WB_CNT_W'(WB_DEPTH));
   assign empty_o   = (r_count == '0);
   assign count_o   = r_count;
   assign data_o    = r_mem[r_rd_ptr];
   assign w_do_push = push_i & ~full_o;
   assign w_do_pop  = pop_i & ~empty_o;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_mem <= '{default: '0};
      end else if (w_do_push) begin
         r_mem[r_wr_ptr] <= data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= wb_ptr_inc(r_wr_ptr);
         end
         if (w_do_pop) begin
            r_rd_ptr <= wb_ptr_inc(r_rd_ptr);
         end
         unique case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + WB_CNT_W'(1);
            2'b01:   r_count <= r_count - WB_CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/cpu_writeback.sv
// Writeback stage: buffers retiring instructions and drives two register-file write ports.
// Define CPU_WB_BYPASS_EN to build the forwarding path on the byp_* ports.
module cpu_writeback
   import mox125_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   cpu_writeback_if.slave       mw,
   input  logic                 hold_i,
   output logic                 rf_we0_o,
   output logic [REG_IDX_W-1:0] rf_idx0_o,
   output logic [DATA_W-1:0]    rf_val0_o,
   output logic                 rf_we1_o,
   output logic [REG_IDX_W-1:0] rf_idx1_o,
   output logic [DATA_W-1:0]    rf_val1_o,
   input  logic [REG_IDX_W-1:0] byp_idx0_i,
   input  logic [REG_IDX_W-1:0] byp_idx1_i,
   output logic                 byp_hit0_o,
   output logic [DATA_W-1:0]    byp_val0_o,
   output logic                 byp_hit1_o,
   output logic [DATA_W-1:0]    byp_val1_o,
   output logic                 retire_o,
   output logic [DATA_W-1:0]    retire_count_o
);

   wb_entry_t           w_in_entry;
   wb_entry_t           w_head;
   wb_entry_t           w_drain_entry;
   logic                w_fifo_full;
   logic                w_fifo_empty;
   logic [WB_CNT_W-1:0] w_fifo_count;
   logic [WB_CNT_W-1:0] w_count_next;
   logic                w_accept;
   logic                w_push;
   logic                w_pop;
   logic                w_drain;
   logic                w_conflict;
   logic                w_ready_next;

   logic                 r_ready;
   logic                 r_we0;
   logic                 r_we1;
   logic [REG_IDX_W-1:0] r_idx0;
   logic [REG_IDX_W-1:0] r_idx1;
   logic [DATA_W-1:0]    r_val0;
   logic [DATA_W-1:0]    r_val1;
   logic                 r_retire;
   logic [DATA_W-1:0]    r_retire_count;

   always_comb begin
      w_in_entry      = '0;
      w_in_entry.we0  = mw.mw_we0_i;
      w_in_entry.idx0 = mw.mw_idx0_i;
      w_in_entry.val0 = mw.mw_val0_i;
      w_in_entry.we1  = mw.mw_we1_i;
      w_in_entry.idx1 = mw.mw_idx1_i;
      w_in_entry.val1 = mw.mw_val1_i;
   end

   assign mw.mw_ready_o = r_ready & ~w_fifo_full;
   assign w_accept      = mw.mw_valid_i & mw.mw_ready_o;
   assign w_pop         = ~hold_i & ~w_fifo_empty;
   // With an empty buffer and no hold the incoming entry bypasses the FIFO entirely.
   assign w_push        = w_accept & (hold_i | ~w_fifo_empty);
   assign w_drain       = ~hold_i & (~w_fifo_empty | w_accept);
   assign w_drain_entry = w_fifo_empty ? w_in_entry : w_head;
   assign w_conflict    = w_drain_entry.we0 & w_drain_entry.we1 &
                          (w_drain_entry.idx0 == w_drain_entry.idx1);
   assign w_count_next  = w_fifo_count + WB_CNT_W'(w_push) - WB_CNT_W'(w_pop);
   assign w_ready_next  = (w_count_next < WB_CNT_W'(WB_DEPTH));

   cpu_wb_fifo u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (w_push),
      .data_i  (w_in_entry),
      .pop_i   (w_pop),
      .data_o  (w_head),
      .full_o  (w_fifo_full),
      .empty_o (w_fifo_empty),
      .count_o (w_fifo_count)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_ready        <= 1'b0;
         r_we0          <= 1'b0;
         r_we1          <= 1'b0;
         r_idx0         <= '0;
         r_idx1         <= '0;
         r_val0         <= '0;
         r_val1         <= '0;
         r_retire       <= 1'b0;
         r_retire_count <= '0;
      end else begin
         r_ready  <= w_ready_next;
         // Port 1 wins a same-register double write.
         r_we0    <= w_drain & w_drain_entry.we0 & ~w_conflict;
         r_we1    <= w_drain & w_drain_entry.we1;
         r_retire <= w_drain;
         if (w_drain) begin
            r_idx0         <= w_drain_entry.idx0;
            r_val0         <= w_drain_entry.val0;
            r_idx1         <= w_drain_entry.idx1;
            r_val1         <= w_drain_entry.val1;
            r_retire_count <= r_retire_count + DATA_W'(1);
         end
      end
   end

   assign rf_we0_o       = r_we0;
   assign rf_idx0_o      = r_idx0;
   assign rf_val0_o      = r_val0;
   assign rf_we1_o       = r_we1;
   assign rf_idx1_o      = r_idx1;
   assign rf_val1_o      = r_val1;
   assign retire_o       = r_retire;
   assign retire_count_o = r_retire_count;

`ifdef CPU_WB_BYPASS_EN
   always_comb begin
      byp_hit0_o = 1'b0;
      byp_val0_o = '0;
      if (r_we1 && (r_idx1 == byp_idx0_i)) begin
         byp_hit0_o = 1'b1;
         byp_val0_o = r_val1;
      end else if (r_we0 && (r_idx0 == byp_idx0_i)) begin
         byp_hit0_o = 1'b1;
         byp_val0_o = r_val0;
      end
   end

   always_comb begin
      byp_hit1_o = 1'b0;
      byp_val1_o = '0;
      if (r_we1 && (r_idx1 == byp_idx1_i)) begin
         byp_hit1_o = 1'b1;
         byp_val1_o = r_val1;
      end else if (r_we0 && (r_idx0 == byp_idx1_i)) begin
         byp_hit1_o = 1'b1;
         byp_val1_o = r_val0;
      end
   end
`else
   logic w_unused_byp;
   assign w_unused_byp = ^{byp_idx0_i, byp_idx1_i};
   assign byp_hit0_o   = 1'b0;
   assign byp_val0_o   = '0;
   assign byp_hit1_o   = 1'b0;
   assign byp_val1_o   = '0;
`endif

endmodule

// File: tb/tb_cpu_writeback.sv
// Bench for cpu_writeback: directed scenarios plus randomized traffic against a queue model.
module tb_cpu_writeback;
   import mox125_pkg::*;

`ifdef CPU_WB_BYPASS_EN
   localparam bit BypEn = 1'b1;
`else
   localparam bit BypEn = 1'b0;
`endif

   logic        clk_i      = 1'b0;
   logic        rst_i      = 1'b0;
   logic        hold_i     = 1'b0;
   logic [3:0]  byp_idx0_i = '0;
   logic [3:0]  byp_idx1_i = '0;
   logic        rf_we0_o, rf_we1_o, byp_hit0_o, byp_hit1_o, retire_o;
   logic [3:0]  rf_idx0_o, rf_idx1_o;
   logic [31:0] rf_val0_o, rf_val1_o, byp_val0_o, byp_val1_o, retire_count_o;

   int n_vec = 0;
   int n_bad = 0;

   cpu_writeback_if mw ();

   cpu_writeback dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .mw             (mw),
      .hold_i         (hold_i),
      .rf_we0_o       (rf_we0_o),
      .rf_idx0_o      (rf_idx0_o),
      .rf_val0_o      (rf_val0_o),
      .rf_we1_o       (rf_we1_o),
      .rf_idx1_o      (rf_idx1_o),
      .rf_val1_o      (rf_val1_o),
      .byp_idx0_i     (byp_idx0_i),
      .byp_idx1_i     (byp_idx1_i),
      .byp_hit0_o     (byp_hit0_o),
      .byp_val0_o     (byp_val0_o),
      .byp_hit1_o     (byp_hit1_o),
      .byp_val1_o     (byp_val1_o),
      .retire_o       (retire_o),
      .retire_count_o (retire_count_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference model: a plain queue of accepted entries, popped once per unheld edge.
   wb_entry_t   m_q[$];
   logic        m_ready, m_we0, m_we1, m_retire;
   logic [3:0]  m_idx0, m_idx1;
   logic [31:0] m_val0, m_val1, m_count;

   task automatic model_reset();
      m_q.delete();
      m_ready  = 1'b0;
      m_we0    = 1'b0;
      m_we1    = 1'b0;
      m_retire = 1'b0;
      m_idx0   = '0;
      m_idx1   = '0;
      m_val0   = '0;
      m_val1   = '0;
      m_count  = '0;
   endtask

   task automatic model_step();
      wb_entry_t t;
      if (mw.mw_valid_i && m_ready) begin
         t.we0  = mw.mw_we0_i;
         t.idx0 = mw.mw_idx0_i;
         t.val0 = mw.mw_val0_i;
         t.we1  = mw.mw_we1_i;
         t.idx1 = mw.mw_idx1_i;
         t.val1 = mw.mw_val1_i;
         m_q.push_back(t);
      end
      m_we0    = 1'b0;
      m_we1    = 1'b0;
      m_retire = 1'b0;
      if (!hold_i && m_q.size() > 0) begin
         t        = m_q.pop_front();
         m_we0    = t.we0 && !(t.we1 && t.idx0 == t.idx1);
         m_we1    = t.we1;
         m_idx0   = t.idx0;
         m_val0   = t.val0;
         m_idx1   = t.idx1;
         m_val1   = t.val1;
         m_retire = 1'b1;
         m_count  = m_count + 32'd1;
      end
      m_ready = (m_q.size() < 2);
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk_i or negedge rst_i);
         if (!rst_i) model_reset();
         else        model_step();
      end
   end

   function automatic logic [32:0] exp_byp(input logic [3:0] idx);
      if (BypEn && m_we1 && m_idx1 == idx) return {1'b1, m_val1};
      if (BypEn && m_we0 && m_idx0 == idx) return {1'b1, m_val0};
      return '0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, on the inactive edge.
   initial begin
      logic [32:0] e0, e1;
      forever begin
         @(negedge clk_i);
         e0 = exp_byp(byp_idx0_i);
         e1 = exp_byp(byp_idx1_i);
         chk("mw_ready",    32'(mw.mw_ready_o), 32'(m_ready));
         chk("rf_we0",      32'(rf_we0_o),      32'(m_we0));
         chk("rf_idx0",     32'(rf_idx0_o),     32'(m_idx0));
         chk("rf_val0",     rf_val0_o,          m_val0);
         chk("rf_we1",      32'(rf_we1_o),      32'(m_we1));
         chk("rf_idx1",     32'(rf_idx1_o),     32'(m_idx1));
         chk("rf_val1",     rf_val1_o,          m_val1);
         chk("retire",      32'(retire_o),      32'(m_retire));
         chk("retire_cnt",  retire_count_o,     m_count);
         chk("byp_hit0",    32'(byp_hit0_o),    32'(e0[32]));
         chk("byp_val0",    byp_val0_o,         e0[31:0]);
         chk("byp_hit1",    32'(byp_hit1_o),    32'(e1[32]));
         chk("byp_val1",    byp_val1_o,         e1[31:0]);
      end
   end

   function automatic wb_entry_t ent(input logic we0, input logic [3:0] idx0,
                                     input logic [31:0] val0, input logic we1,
                                     input logic [3:0] idx1, input logic [31:0] val1);
      wb_entry_t e;
      e.we0  = we0;
      e.idx0 = idx0;
      e.val0 = val0;
      e.we1  = we1;
      e.idx1 = idx1;
      e.val1 = val1;
      return e;
   endfunction

   // Called at a falling edge; drives just after it and returns at the next falling edge.
   task automatic cyc(input logic v, input wb_entry_t t, input logic h);
      #1;
      mw.mw_valid_i = v;
      mw.mw_we0_i   = t.we0;
      mw.mw_idx0_i  = t.idx0;
      mw.mw_val0_i  = t.val0;
      mw.mw_we1_i   = t.we1;
      mw.mw_idx1_i  = t.idx1;
      mw.mw_val1_i  = t.val1;
      hold_i        = h;
      @(negedge clk_i);
   endtask

   wb_entry_t idle_e;
   wb_entry_t r_e;

   initial begin
      idle_e = ent(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
      mw.mw_valid_i = 1'b0;
      mw.mw_we0_i   = 1'b0;
      mw.mw_idx0_i  = '0;
      mw.mw_val0_i  = '0;
      mw.mw_we1_i   = 1'b0;
      mw.mw_idx1_i  = '0;
      mw.mw_val1_i  = '0;

      repeat (2) @(negedge clk_i);
      chk("reset_ready", 32'(mw.mw_ready_o), 32'd0);
      chk("reset_count", retire_count_o, 32'd0);
      #1 rst_i = 1'b1;
      @(negedge clk_i);
      chk("ready_after_release", 32'(mw.mw_ready_o), 32'd1);

      // Single push into an empty FIFO writes the next cycle.
      cyc(1'b1, ent(1'b1, 4'd3, 32'hDEAD_BEEF, 1'b0, 4'd0, 32'd0), 1'b0);
      chk("direct_we0",   32'(rf_we0_o),  32'd1);
      chk("direct_idx0",  32'(rf_idx0_o), 32'd3);
      chk("direct_val0",  rf_val0_o,      32'hDEAD_BEEF);
      chk("direct_ret",   32'(retire_o),  32'd1);
      chk("direct_cnt",   retire_count_o, 32'd1);
      cyc(1'b0, idle_e, 1'b0);
      chk("idle_we0",     32'(rf_we0_o),  32'd0);
      chk("idle_idx0",    32'(rf_idx0_o), 32'd3);
      chk("idle_ret",     32'(retire_o),  32'd0);

      // Forwarding from port 0.
      #1 byp_idx1_i = 4'd2;
      cyc(1'b1, ent(1'b1, 4'd2, 32'h11, 1'b0, 4'd0, 32'd0), 1'b0);
      chk("byp1_hit", 32'(byp_hit1_o), BypEn ? 32'd1 : 32'd0);
      chk("byp1_val", byp_val1_o,      BypEn ? 32'h11 : 32'd0);
      chk("byp_cnt",  retire_count_o,  32'd2);

      // Hold: two accepts fill the FIFO, then release drains in order.
      cyc(1'b1, ent(1'b1, 4'd4, 32'hA0, 1'b0, 4'd0, 32'd0), 1'b1);
      chk("hold_rdy1",  32'(mw.mw_ready_o), 32'd1);
      chk("hold_we0",   32'(rf_we0_o),      32'd0);
      cyc(1'b1, ent(1'b1, 4'd5, 32'hB0, 1'b0, 4'd0, 32'd0), 1'b1);
      chk("hold_rdy2",  32'(mw.mw_ready_o), 32'd0);
      cyc(1'b1, ent(1'b1, 4'd6, 32'hC0, 1'b0, 4'd0, 32'd0), 1'b1);
      chk("hold_rdy3",  32'(mw.mw_ready_o), 32'd0);
      chk("hold_cnt",   retire_count_o,     32'd2);
      chk("hold_ret",   32'(retire_o),      32'd0);
      cyc(1'b1, ent(1'b1, 4'd6, 32'hC0, 1'b0, 4'd0, 32'd0), 1'b0);
      chk("drainA_val", rf_val0_o,          32'hA0);
      chk("drainA_idx", 32'(rf_idx0_o),     32'd4);
      chk("drainA_cnt", retire_count_o,     32'd3);
      chk("drainA_rdy", 32'(mw.mw_ready_o), 32'd1);
      cyc(1'b1, ent(1'b1, 4'd6, 32'hC0, 1'b0, 4'd0, 32'd0), 1'b0);
      chk("drainB_val", rf_val0_o,          32'hB0);
      chk("drainB_cnt", retire_count_o,     32'd4);
      cyc(1'b0, idle_e, 1'b0);
      chk("drainC_val", rf_val0_o,          32'hC0);
      chk("drainC_we0", 32'(rf_we0_o),      32'd1);
      chk("drainC_cnt", retire_count_o,     32'd5);

      // Same register on both ports: port 1 wins.
      cyc(1'b1, ent(1'b1, 4'd1, 32'd5, 1'b1, 4'd1, 32'd9), 1'b0);
      chk("conf_we0",  32'(rf_we0_o),  32'd0);
      chk("conf_we1",  32'(rf_we1_o),  32'd1);
      chk("conf_val1", rf_val1_o,      32'd9);
      chk("conf_cnt",  retire_count_o, 32'd6);

      // Counter wrap; an entry with no enables still retires.
      cyc(1'b0, idle_e, 1'b0);
      #2;
      force dut.r_retire_count = 32'hFFFF_FFFF;
      m_count = 32'hFFFF_FFFF;
      #1;
      release dut.r_retire_count;
      cyc(1'b1, idle_e, 1'b0);
      chk("wrap_cnt", retire_count_o, 32'd0);
      chk("wrap_ret", 32'(retire_o),  32'd1);
      chk("wrap_we0", 32'(rf_we0_o),  32'd0);
      chk("wrap_we1", 32'(rf_we1_o),  32'd0);

      // Reset with two buffered entries.
      cyc(1'b1, ent(1'b1, 4'd7, 32'h77, 1'b1, 4'd8, 32'h88), 1'b1);
      cyc(1'b1, ent(1'b1, 4'd9, 32'h99, 1'b0, 4'd0, 32'd0), 1'b1);
      #1 rst_i = 1'b0;
      #1;
      chk("rst_ready", 32'(mw.mw_ready_o), 32'd0);
      chk("rst_we0",   32'(rf_we0_o),      32'd0);
      chk("rst_val0",  rf_val0_o,          32'd0);
      chk("rst_idx1",  32'(rf_idx1_o),     32'd0);
      chk("rst_val1",  rf_val1_o,          32'd0);
      chk("rst_cnt",   retire_count_o,     32'd0);
      @(negedge clk_i);
      #1 rst_i = 1'b1;
      cyc(1'b0, idle_e, 1'b0);
      chk("post_rst_ready", 32'(mw.mw_ready_o), 32'd1);
      chk("post_rst_ret",   32'(retire_o),      32'd0);
      cyc(1'b0, idle_e, 1'b0);
      chk("post_rst_we0",   32'(rf_we0_o),      32'd0);
      chk("post_rst_we1",   32'(rf_we1_o),      32'd0);
      chk("post_rst_cnt",   retire_count_o,     32'd0);

      // Randomized traffic checked by the model.
      for (int i = 0; i < 3000; i++) begin
         r_e.we0  = 1'($urandom_range(0, 1));
         r_e.idx0 = 4'($urandom_range(0, 15));
         r_e.val0 = $urandom;
         r_e.we1  = 1'($urandom_range(0, 1));
         r_e.idx1 = ($urandom_range(0, 3) == 0) ? r_e.idx0 : 4'($urandom_range(0, 15));
         r_e.val1 = $urandom;
         if ($urandom_range(0, 499) == 0) begin
            #1 rst_i = 1'b0;
            @(negedge clk_i);
            #1 rst_i = 1'b1;
         end
         #1;
         byp_idx0_i = 4'($urandom_range(0, 15));
         byp_idx1_i = 4'($urandom_range(0, 15));
         cyc(($urandom_range(0, 9) < 6), r_e, ($urandom_range(0, 9) < 2));
      end

      cyc(1'b0, idle_e, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
